// File: rtl/perceptron_train_engine.sv
// perceptron_train_engine
//   Retrains one perceptron predictor row after a branch resolves. Each
//   accepted request is either skipped or trained. A skipped request was
//   predicted correctly with a confident |sum|. A trained request has every
//   history weight nudged toward agreement with the outcome, LANES weights
//   per cycle, and then the row is offered for write-back.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_index/ghr/weights/bias   row being trained
//   req_dir/pred/sum             outcome, prediction and prediction sum
//   flush                        abort any in-flight update (no write)
//   wr_valid/wr_ready            write-back handshake
//   wr_index/weights/bias        updated row
//   busy                         engine not idle
//   train_cnt/skip_cnt           saturating request counters
module perceptron_train_engine #(
  parameter int HIST_LEN = 16,
  parameter int W_BITS   = 3,
  parameter int LANES    = 4,
  parameter int THETA    = 4,
  parameter int SUM_BITS = 9,
  parameter int IDX_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_BITS-1:0]        req_index,
  input  logic [HIST_LEN-1:0]        req_ghr,
  input  logic [HIST_LEN*W_BITS-1:0] req_weights,
  input  logic [W_BITS-1:0]          req_bias,
  input  logic                       req_dir,
  input  logic                       req_pred,
  input  logic [SUM_BITS-1:0]        req_sum,
  input  logic                       flush,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [IDX_BITS-1:0]        wr_index,
  output logic [HIST_LEN*W_BITS-1:0] wr_weights,
  output logic [W_BITS-1:0]          wr_bias,
  output logic                       busy,
  output logic [15:0]                train_cnt,
  output logic [15:0]                skip_cnt
);

  if (HIST_LEN % LANES != 0) begin : g_bad_lanes
    $error("HIST_LEN must be a multiple of LANES");
  end

  localparam int NCHUNK = HIST_LEN / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]       LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [W_BITS-1:0]   W_MAX      = {1'b0, {(W_BITS-1){1'b1}}};
  localparam logic [W_BITS-1:0]   W_MIN      = {1'b1, {(W_BITS-1){1'b0}}};
  localparam logic [SUM_BITS-1:0] THETA_V    = SUM_BITS'(THETA);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UPD  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]                 r_state;
  logic [CW-1:0]              r_chunk;
  logic [IDX_BITS-1:0]        r_index;
  logic [HIST_LEN-1:0]        r_ghr;
  logic [HIST_LEN*W_BITS-1:0] r_weights;
  logic [W_BITS-1:0]          r_bias;
  logic                       r_dir;
  logic [15:0]                r_train_cnt;
  logic [15:0]                r_skip_cnt;

  logic                       w_hs;
  logic                       w_sum_neg;
  logic                       w_sum_min;
  logic [SUM_BITS-1:0]        w_sum_mag;
  logic                       w_train;
  logic [HIST_LEN*W_BITS-1:0] w_weights_nxt;

  // Step a weight one unit toward +max (up) or -min, sticking at the rails.
  function automatic logic [W_BITS-1:0] sat_step(input logic [W_BITS-1:0] w,
                                                 input logic up);
    if (up) return (w == W_MAX) ? w : w + 1'b1;
    else    return (w == W_MIN) ? w : w - 1'b1;
  endfunction

  assign req_ready  = (r_state == S_IDLE) && !flush;
  assign w_hs       = req_valid && req_ready;
  assign busy       = (r_state != S_IDLE);
  assign wr_valid   = (r_state == S_WR);
  assign wr_index   = r_index;
  assign wr_weights = r_weights;
  assign wr_bias    = r_bias;
  assign train_cnt  = r_train_cnt;
  assign skip_cnt   = r_skip_cnt;

  // |sum| cannot be represented for the most-negative value; that value is
  // always far outside the threshold, so it is excluded explicitly.
  assign w_sum_neg = req_sum[SUM_BITS-1];
  assign w_sum_min = w_sum_neg && (req_sum[SUM_BITS-2:0] == '0);
  assign w_sum_mag = w_sum_neg ? (~req_sum + 1'b1) : req_sum;
  assign w_train   = (req_pred != req_dir) || (!w_sum_min && (w_sum_mag <= THETA_V));

  // Only the LANES weights of the current chunk change; the rest pass through.
  always_comb begin
    w_weights_nxt = r_weights;
    for (int l = 0; l < LANES; l++) begin
      w_weights_nxt[(int'(r_chunk)*LANES + l)*W_BITS +: W_BITS] =
        sat_step(r_weights[(int'(r_chunk)*LANES + l)*W_BITS +: W_BITS],
                 r_dir == r_ghr[int'(r_chunk)*LANES + l]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_chunk     <= '0;
      r_index     <= '0;
      r_ghr       <= '0;
      r_weights   <= '0;
      r_bias      <= '0;
      r_dir       <= 1'b0;
      r_train_cnt <= '0;
      r_skip_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_index   <= req_index;
            r_ghr     <= req_ghr;
            r_weights <= req_weights;
            r_bias    <= req_bias;
            r_dir     <= req_dir;
            if (w_train) begin
              r_state <= S_UPD;
              r_chunk <= '0;
              if (r_train_cnt != 16'hFFFF) r_train_cnt <= r_train_cnt + 16'd1;
            end else begin
              if (r_skip_cnt != 16'hFFFF) r_skip_cnt <= r_skip_cnt + 16'd1;
            end
          end
        end
        S_UPD: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_chunk <= '0;
          end else begin
            r_weights <= w_weights_nxt;
            if (r_chunk == '0) r_bias <= sat_step(r_bias, r_dir);
            if (r_chunk == LAST_CHUNK) begin
              r_state <= S_WR;
              r_chunk <= '0;
            end else begin
              r_chunk <= r_chunk + 1'b1;
            end
          end
        end
        S_WR: begin
          // A flush landing on the accepting cycle still counts as written.
          if (wr_ready || flush) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_train_engine.sv
module tb_perceptron_train_engine;
  localparam int HL  = 16;
  localparam int WB  = 3;
  localparam int LN  = 4;
  localparam int TH  = 4;
  localparam int SB  = 9;
  localparam int IB  = 8;
  localparam int NCH = HL / LN;
  localparam int WMAX = (1 << (WB-1)) - 1;
  localparam int WMIN = -(1 << (WB-1));

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [IB-1:0]     req_index;
  logic [HL-1:0]     req_ghr;
  logic [HL*WB-1:0]  req_weights;
  logic [WB-1:0]     req_bias;
  logic              req_dir, req_pred;
  logic [SB-1:0]     req_sum;
  logic              flush;
  logic              wr_valid, wr_ready;
  logic [IB-1:0]     wr_index;
  logic [HL*WB-1:0]  wr_weights;
  logic [WB-1:0]     wr_bias;
  logic              busy;
  logic [15:0]       train_cnt, skip_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int m_train = 0;
  int m_skip  = 0;

  always #5 clk = ~clk;

  perceptron_train_engine #(
    .HIST_LEN(HL), .W_BITS(WB), .LANES(LN), .THETA(TH), .SUM_BITS(SB), .IDX_BITS(IB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_ghr(req_ghr), .req_weights(req_weights),
    .req_bias(req_bias), .req_dir(req_dir), .req_pred(req_pred), .req_sum(req_sum),
    .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_weights(wr_weights), .wr_bias(wr_bias),
    .busy(busy), .train_cnt(train_cnt), .skip_cnt(skip_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic bit model_train(input logic [SB-1:0] s, input logic p, input logic d);
    logic signed [SB-1:0] ss;
    int v;
    ss = s;
    v  = ss;
    if (v < 0) v = -v;
    return (p != d) || (v <= TH);
  endfunction

  function automatic logic [HL*WB-1:0] model_row(input logic [HL*WB-1:0] w,
                                                 input logic [HL-1:0] g, input logic d);
    logic [HL*WB-1:0]     r;
    logic signed [WB-1:0] f;
    int v;
    r = '0;
    for (int i = 0; i < HL; i++) begin
      f = w[i*WB +: WB];
      v = f;
      v = clamp((d == g[i]) ? v + 1 : v - 1);
      r[i*WB +: WB] = v[WB-1:0];
    end
    return r;
  endfunction

  function automatic logic [WB-1:0] model_bias(input logic [WB-1:0] b, input logic d);
    logic signed [WB-1:0] f;
    int v;
    f = b;
    v = f;
    v = clamp(d ? v + 1 : v - 1);
    return v[WB-1:0];
  endfunction

  // abort: 0 none, k>0 flush during cycle k after handshake, -1 reset once in WRITE
  task automatic run_txn(input logic [IB-1:0] idx, input logic [HL-1:0] g,
                         input logic [HL*WB-1:0] w, input logic [WB-1:0] b,
                         input logic d, input logic p, input logic [SB-1:0] s,
                         input int hold, input int abort);
    bit               tr;
    logic [HL*WB-1:0] ew;
    logic [WB-1:0]    eb;
    int               cyc;
    tr = model_train(s, p, d);
    ew = model_row(w, g, d);
    eb = model_bias(b, d);
    chk("req_ready_idle", req_ready, 1'b1);
    req_index = idx; req_ghr = g; req_weights = w; req_bias = b;
    req_dir = d; req_pred = p; req_sum = s; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_index = IB'($urandom); req_ghr = HL'($urandom);
    req_weights = {$urandom, $urandom}; req_bias = WB'($urandom);
    req_dir = 1'($urandom); req_sum = SB'($urandom);
    if (!tr) begin
      m_skip++;
      chk("skip_busy", busy, 1'b0);
      chk("skip_cnt", skip_cnt, 16'(m_skip));
      chk("skip_train_cnt", train_cnt, 16'(m_train));
      tick();
      chk("skip_no_write", wr_valid, 1'b0);
      return;
    end
    m_train++;
    chk("train_cnt", train_cnt, 16'(m_train));
    chk("train_busy", busy, 1'b1);
    for (cyc = 1; cyc < 40; cyc++) begin
      if (cyc == abort) begin
        flush = 1'b1;
        wr_ready = 1'($urandom);
        chk("flush_rdy", req_ready, 1'b0);
        tick();
        flush = 1'b0;
        wr_ready = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_wr_valid", wr_valid, 1'b0);
        chk("flush_train_cnt", train_cnt, 16'(m_train));
        tick();
        chk("flush_no_write", wr_valid, 1'b0);
        return;
      end
      if (wr_valid) break;
      tick();
    end
    chk("latency", cyc, NCH + 1);
    chk("wr_valid", wr_valid, 1'b1);
    chk("wr_index", wr_index, idx);
    chk("wr_weights", wr_weights, ew);
    chk("wr_bias", wr_bias, eb);
    if (abort == -1) begin
      rst = 1'b1;
      #1;
      m_train = 0;
      m_skip  = 0;
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cnts", {train_cnt, skip_cnt}, 32'h0);
      chk("rst_row", {wr_index, wr_bias, wr_weights}, 64'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_req_ready", req_ready, 1'b1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", wr_valid, 1'b1);
      chk("hold_row", {wr_index, wr_bias, wr_weights}, {idx, eb, ew});
      chk("hold_req_ready", req_ready, 1'b0);
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("done_wr_valid", wr_valid, 1'b0);
    chk("done_busy", busy, 1'b0);
    chk("done_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HL*WB-1:0] w;
    logic [SB-1:0]    s;
    int               sv;
    rst = 1'b1; req_valid = 1'b0; req_index = '0; req_ghr = '0; req_weights = '0;
    req_bias = '0; req_dir = 1'b0; req_pred = 1'b0; req_sum = '0;
    flush = 1'b0; wr_ready = 1'b0;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_wr_valid", wr_valid, 1'b0);
    chk("reset_cnts", {train_cnt, skip_cnt}, 32'h0);
    chk("reset_row", {wr_index, wr_bias, wr_weights}, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_ready", req_ready, 1'b1);

    // confident correct prediction: skipped
    run_txn(8'h11, 16'h1234, '0, 3'd0, 1'b1, 1'b1, 9'd20, 0, 0);
    // misprediction, all history agrees with not-taken? no: ghr=1, dir=0 -> all decrement
    run_txn(8'h22, 16'hFFFF, '0, 3'b000, 1'b0, 1'b1, 9'd0, 0, 0);
    // correct but |sum| == THETA: trains, saturation at both rails
    w = '0;
    for (int i = 1; i < HL; i++) w[i*WB +: WB] = 3'b100;
    w[2:0] = 3'd3;
    run_txn(8'h33, 16'h0001, w, 3'd0, 1'b1, 1'b1, 9'd4, 0, 0);
    // write-back stalled for three cycles
    run_txn(8'h44, 16'hA5A5, {$urandom, $urandom}, 3'd2, 1'b1, 1'b0, 9'd100, 3, 0);
    // boundary sums: -4 trains, -5 skips, most-negative skips
    run_txn(8'h55, 16'h0F0F, {$urandom, $urandom}, 3'd1, 1'b0, 1'b0, 9'h1FC, 0, 0);
    run_txn(8'h56, 16'h0F0F, {$urandom, $urandom}, 3'd1, 1'b0, 1'b0, 9'h1FB, 0, 0);
    run_txn(8'h57, 16'h0F0F, {$urandom, $urandom}, 3'd1, 1'b0, 1'b0, 9'h100, 0, 0);
    // flush in cycle 2 (UPDATE), flush in WRITE, then reset in WRITE
    run_txn(8'h66, 16'h00FF, {$urandom, $urandom}, 3'd0, 1'b1, 1'b0, 9'd0, 0, 2);
    run_txn(8'h67, 16'h00FF, {$urandom, $urandom}, 3'd0, 1'b1, 1'b0, 9'd0, 0, NCH + 1);
    run_txn(8'h77, 16'hF00F, {$urandom, $urandom}, 3'd3, 1'b1, 1'b0, 9'd0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       sv = -256;
        1:       sv = -5;
        2:       sv = -4;
        3:       sv = 4;
        4:       sv = 5;
        default: sv = int'($urandom_range(0, 511)) - 256;
      endcase
      s = sv[SB-1:0];
      run_txn(IB'($urandom), HL'($urandom), {$urandom, $urandom}, WB'($urandom),
              1'($urandom), 1'($urandom), s, int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, NCH + 1)) : 0);
    end
    chk("final_train_cnt", train_cnt, 16'(m_train));
    chk("final_skip_cnt", skip_cnt, 16'(m_skip));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
